// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock, LSB first.
// Result, borrow and zero flags are registered and only change on DONE entry.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              br_q, br_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              borrow_q, borrow_d;
   logic              zero_q, zero_d;

   logic              ai, bi, d_bit, br_next;
   logic [WIDTH-1:0]  res_shift;

   always_comb begin
      ai        = a_q[0];
      bi        = b_q[0];
      d_bit     = ai ^ bi ^ br_q;
      br_next   = (~ai & bi) | (~(ai ^ bi) & br_q);
      // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
      res_shift = {d_bit, res_q[WIDTH-1:1]};

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               res_d   = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_shift;
            br_d  = br_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d  = StDone;
               diff_d   = res_shift;
               borrow_d = br_next;
               zero_d   = (res_shift == '0);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign zero   = zero_q;

endmodule
